// File: rtl/cxu_aes_sbox_if.sv
// ---------------------------------------------------------------------------
// cxu_aes_sbox_if
// CXU command/response bus shared by the AES SubBytes and GF(2^8) multiply
// units.
//   cmd_valid / cmd_ready      : command handshake (master -> slave)
//   cmd_payload_function_id    : operation select, unit-specific
//   cmd_payload_inputs_0/1     : 32-bit operands
//   cmd_payload_state_id       : state slot select (unused by stateless units)
//   cmd_payload_cxu_id         : unit select (decoded upstream)
//   cmd_payload_ready          : auxiliary ready flag carried with the command
//   rsp_valid / rsp_ready      : response handshake (slave -> master)
//   rsp_payload_outputs_0      : 32-bit result
//   rsp_payload_ready          : auxiliary ready flag carried with the response
// The master modport is the issuing core, the slave modport is the CXU.
// ---------------------------------------------------------------------------
interface cxu_aes_sbox_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic [2:0]  cmd_payload_state_id;
  logic [3:0]  cmd_payload_cxu_id;
  logic        cmd_payload_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        rsp_payload_ready;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id,
           cmd_payload_ready, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id,
           cmd_payload_ready, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
  );
endinterface

// File: rtl/cxu_aes_sbox.sv
// ---------------------------------------------------------------------------
// cxu_aes_sbox
// Applies the AES S-box (function_id[0]=0) or inverse S-box (function_id[0]=1)
// to the four bytes of cmd_payload_inputs_0. The field inverse is computed as
// x^254 in GF(2^8) mod 0x11B by MSB-first square-and-multiply, one exponent
// bit per clock for all four lanes in parallel, so a result is ready 8 clocks
// after the command is accepted.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; returns the unit to IDLE
//   bus   : CXU command/response bus (slave side)
// ---------------------------------------------------------------------------
module cxu_aes_sbox (
  input  logic           clk,
  input  logic           reset,
  cxu_aes_sbox_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Exponent 254 = multiplicative inverse (and maps 0 to 0).
  localparam logic [7:0] INV_EXP = 8'hFE;

  // Carry-less 8x8 multiply reduced by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Forward affine: out_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ 0x63_i.
  // A right-rotate by n places b_(i+n) at bit i.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
             ^ {b[6:0], b[7]} ^ 8'h63;
  endfunction

  // Inverse affine: out_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ 0x05_i.
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
  endfunction

  state_e          state_q;
  logic            mode_q;       // 1 = inverse S-box
  logic [2:0]      cnt_q;        // exponent bit processed by the next step
  logic [3:0][7:0] x_q;          // per-lane base
  logic [3:0][7:0] r_q;          // per-lane running power
  logic [31:0]     result_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;

  logic [3:0][7:0] sq_w;
  logic [3:0][7:0] step_w;
  logic [3:0][7:0] fwd_w;
  logic [3:0][7:0] base_w;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sq_w   = '0;
    step_w = '0;
    fwd_w  = '0;
    base_w = '0;
    for (int k = 0; k < 4; k++) begin
      sq_w[k]   = gmul(r_q[k], r_q[k]);
      step_w[k] = INV_EXP[cnt_q] ? gmul(sq_w[k], x_q[k]) : sq_w[k];
      fwd_w[k]  = affine(step_w[k]);
      base_w[k] = bus.cmd_payload_function_id[0]
                    ? inv_affine(bus.cmd_payload_inputs_0[8*k +: 8])
                    : bus.cmd_payload_inputs_0[8*k +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the lane registers are few flops, not a memory, so they are
      // reset along with the control state for deterministic outputs.
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= 3'd0;
      x_q         <= '0;
      r_q         <= '0;
      result_q    <= 32'h0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            mode_q      <= bus.cmd_payload_function_id[0];
            x_q         <= base_w;
            r_q         <= {4{8'h01}};
            cnt_q       <= 3'd7;
            state_q     <= CALC;
            cmd_ready_q <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= step_w;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            result_q    <= mode_q ? step_w : fwd_w;
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready             = cmd_ready_q;
  assign bus.rsp_valid             = rsp_valid_q;
  assign bus.rsp_payload_outputs_0 = result_q;
  assign bus.rsp_payload_ready     = 1'b1;

  // Bus fields this unit does not decode.
  logic unused_w;
  assign unused_w = ^{bus.cmd_payload_inputs_1, bus.cmd_payload_state_id,
                      bus.cmd_payload_cxu_id, bus.cmd_payload_ready,
                      bus.cmd_payload_function_id[2:1]};

endmodule
